// File: rtl/trig_pkg.sv
// trig_pkg: shared encodings for the coincidence trigger generator.
//   MODE_*  : trigger condition select (OR-all, front AND rear, front only, rear only)
//   state_e : dead-time FSM states
package trig_pkg;

    localparam logic [1:0] MODE_OR    = 2'd0;
    localparam logic [1:0] MODE_AND   = 2'd1;
    localparam logic [1:0] MODE_FRONT = 2'd2;
    localparam logic [1:0] MODE_REAR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DEAD = 2'd2
    } state_e;

endpackage

// File: rtl/chan_stretch.sv
// chan_stretch: one discriminator channel. Registers the input twice for edge
// detection and stretches each rising edge into a window of stretch_len cycles
// using a reloadable down-counter.
//   clk, rst_n   : clock, async active-low reset
//   inp          : raw discriminator input, already synchronous to clk
//   enable       : channel mask bit (1 = enabled)
//   stretch_len  : window length in cycles, 0 disables the channel
//   ch_act       : stretched window active
module chan_stretch #(
    parameter int unsigned STR_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inp,
    input  logic             enable,
    input  logic [STR_W-1:0] stretch_len,
    output logic             ch_act
);

    logic             inp_q;
    logic             inp_qq;
    logic             rise;
    logic [STR_W-1:0] cnt_q;

    assign rise   = inp_q & ~inp_qq & enable;
    assign ch_act = (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inp_q  <= 1'b0;
            inp_qq <= 1'b0;
            cnt_q  <= '0;
        end else begin
            inp_q  <= inp;
            inp_qq <= inp_q;
            // Masked or disabled channels drop their window on the next cycle.
            if (!enable || (stretch_len == '0)) begin
                cnt_q <= '0;
            end else if (rise) begin
                cnt_q <= stretch_len;  // retrigger extends the window
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/coinc_trig_gen2.sv
// coinc_trig_gen2: front/rear scatter trigger. Per-channel mask + stretcher,
// group OR and mode select, prescaled candidate acceptance and a dead-time FSM
// that drives the trigger pulse and MQDC gate.
//   clk, rst_n                  : clock, async active-low reset
//   inp, chan_mask              : discriminator inputs and per-channel enables
//   mode                        : condition select (see trig_pkg MODE_*)
//   stretch_len                 : stretcher window length
//   trig_len, gate_len, dead_len: output widths and dead time, latched on accept
//   prescale                    : accept 1 of every prescale candidates
//   ext_veto                    : discards candidates while high
//   trig_out, gate_out, busy    : trigger pulse, gate, FSM not idle
//   cand_count, acc_count       : saturating candidate / accepted totals
module coinc_trig_gen2
    import trig_pkg::*;
#(
    parameter int unsigned N_FRONT = 18,
    parameter int unsigned N_REAR  = 28,
    parameter int unsigned STR_W   = 6,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned PRE_W   = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_FRONT+N_REAR-1:0] inp,
    input  logic [N_FRONT+N_REAR-1:0] chan_mask,
    input  logic [1:0]                mode,
    input  logic [STR_W-1:0]          stretch_len,
    input  logic [LEN_W-1:0]          trig_len,
    input  logic [LEN_W-1:0]          gate_len,
    input  logic [LEN_W-1:0]          dead_len,
    input  logic [PRE_W-1:0]          prescale,
    input  logic                      ext_veto,
    output logic                      trig_out,
    output logic                      gate_out,
    output logic                      busy,
    output logic [CNT_W-1:0]          cand_count,
    output logic [CNT_W-1:0]          acc_count
);

    localparam int unsigned NCH = N_FRONT + N_REAR;

    logic [NCH-1:0]   ch_act;
    logic             front_or;
    logic             rear_or;
    logic             cond;
    logic             cond_d;
    logic             cand;
    logic             accept;
    logic [PRE_W-1:0] pre_last;
    logic [PRE_W-1:0] pre_cnt;
    logic [LEN_W-1:0] trig_ld;
    logic [LEN_W-1:0] gate_ld;
    logic [LEN_W-1:0] trig_cnt;
    logic [LEN_W-1:0] gate_cnt;
    logic [LEN_W-1:0] dead_cnt;
    state_e           state;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        chan_stretch #(
            .STR_W(STR_W)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .inp        (inp[i]),
            .enable     (chan_mask[i]),
            .stretch_len(stretch_len),
            .ch_act     (ch_act[i])
        );
    end

    assign front_or = |ch_act[N_FRONT-1:0];
    assign rear_or  = |ch_act[NCH-1:N_FRONT];

    always_comb begin
        cond = 1'b0;
        case (mode)
            MODE_OR:    cond = front_or | rear_or;
            MODE_AND:   cond = front_or & rear_or;
            MODE_FRONT: cond = front_or;
            MODE_REAR:  cond = rear_or;
            default:    cond = 1'b0;
        endcase
    end

    assign cand     = cond & ~cond_d & (state == IDLE) & ~ext_veto;
    // prescale 0 and 1 both mean "accept every candidate".
    assign pre_last = (prescale == '0) ? '0 : prescale - 1'b1;
    // >= rather than == so a prescale lowered mid-run cannot strand the counter.
    assign accept   = cand & (pre_cnt >= pre_last);
    assign trig_ld  = (trig_len == '0) ? LEN_W'(1) : trig_len;
    assign gate_ld  = (gate_len == '0) ? LEN_W'(1) : gate_len;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cond_d     <= 1'b0;
            pre_cnt    <= '0;
            trig_cnt   <= '0;
            gate_cnt   <= '0;
            dead_cnt   <= '0;
            trig_out   <= 1'b0;
            gate_out   <= 1'b0;
            cand_count <= '0;
            acc_count  <= '0;
        end else begin
            cond_d <= cond;
            if (cand) begin
                if (cand_count != '1) cand_count <= cand_count + 1'b1;
                pre_cnt <= accept ? '0 : pre_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= FIRE;
                        trig_cnt <= trig_ld;
                        gate_cnt <= gate_ld;
                        dead_cnt <= dead_len;
                        trig_out <= 1'b1;
                        gate_out <= 1'b1;
                        if (acc_count != '1) acc_count <= acc_count + 1'b1;
                    end
                end
                FIRE: begin
                    // Counters hold the remaining high cycles including the current one.
                    if (trig_cnt != '0) trig_cnt <= trig_cnt - 1'b1;
                    if (gate_cnt != '0) gate_cnt <= gate_cnt - 1'b1;
                    trig_out <= (trig_cnt > LEN_W'(1));
                    gate_out <= (gate_cnt > LEN_W'(1));
                    if ((trig_cnt <= LEN_W'(1)) && (gate_cnt <= LEN_W'(1))) begin
                        state <= (dead_cnt == '0) ? IDLE : DEAD;
                    end
                end
                DEAD: begin
                    if (dead_cnt != '0) dead_cnt <= dead_cnt - 1'b1;
                    if (dead_cnt <= LEN_W'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coinc_trig_gen2.sv
module tb_coinc_trig_gen2;

    localparam int NCH = 46;

    logic            clk;
    logic            rst_n;
    logic [NCH-1:0]  inp;
    logic [NCH-1:0]  chan_mask;
    logic [1:0]      mode;
    logic [5:0]      stretch_len;
    logic [7:0]      trig_len;
    logic [7:0]      gate_len;
    logic [7:0]      dead_len;
    logic [15:0]     prescale;
    logic            ext_veto;
    logic            trig_out;
    logic            gate_out;
    logic            busy;
    logic [31:0]     cand_count;
    logic [31:0]     acc_count;

    int n_total = 0;
    int n_bad   = 0;

    coinc_trig_gen2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .inp        (inp),
        .chan_mask  (chan_mask),
        .mode       (mode),
        .stretch_len(stretch_len),
        .trig_len   (trig_len),
        .gate_len   (gate_len),
        .dead_len   (dead_len),
        .prescale   (prescale),
        .ext_veto   (ext_veto),
        .trig_out   (trig_out),
        .gate_out   (gate_out),
        .busy       (busy),
        .cand_count (cand_count),
        .acc_count  (acc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Input goes high for one cycle; returns just after the edge that samples it.
    task automatic pulse(input int ch);
        inp[ch] = 1'b1;
        step();
        inp[ch] = 1'b0;
    endtask

    // Counts high cycles of the outputs over n samples, starting with the current one.
    task automatic watch(input int n, output int t_hi, output int g_hi, output int b_hi);
        t_hi = 0; g_hi = 0; b_hi = 0;
        for (int i = 0; i < n; i++) begin
            if (trig_out) t_hi++;
            if (gate_out) g_hi++;
            if (busy) b_hi++;
            step();
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) step();
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (4) step();
    endtask

    int        t_hi, g_hi, b_hi;
    logic [8:0] pat;

    initial begin
        rst_n       = 1'b0;
        inp         = '0;
        chan_mask   = '1;
        mode        = 2'd0;
        stretch_len = 6'd6;
        trig_len    = 8'd4;
        gate_len    = 8'd20;
        dead_len    = 8'd10;
        prescale    = 16'd1;
        ext_veto    = 1'b0;

        // Reset state
        #12;
        chk("rst_trig", {31'd0, trig_out}, 32'd0);
        chk("rst_gate", {31'd0, gate_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cand", cand_count, 32'd0);
        chk("rst_acc", acc_count, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();

        // Basic OR trigger: latency and widths
        pulse(3);
        chk("t1_k_trig", {31'd0, trig_out}, 32'd0);
        step();
        chk("t1_k1_trig", {31'd0, trig_out}, 32'd0);
        chk("t1_k1_busy", {31'd0, busy}, 32'd0);
        step();
        chk("t1_k2_trig", {31'd0, trig_out}, 32'd1);
        chk("t1_k2_gate", {31'd0, gate_out}, 32'd1);
        watch(40, t_hi, g_hi, b_hi);
        chk("t1_trig_w", t_hi, 32'd4);
        chk("t1_gate_w", g_hi, 32'd20);
        chk("t1_busy_w", b_hi, 32'd30);
        chk("t1_cand", cand_count, 32'd1);
        chk("t1_acc", acc_count, 32'd1);
        wait_idle();

        // Front AND rear: 5-cycle separation overlaps, 8-cycle does not
        mode = 2'd1;
        pulse(0);
        repeat (4) step();
        pulse(20);
        watch(40, t_hi, g_hi, b_hi);
        chk("t2_and_trig", t_hi, 32'd4);
        wait_idle();
        chk("t2_and_cand", cand_count, 32'd2);
        chk("t2_and_acc", acc_count, 32'd2);
        pulse(0);
        repeat (7) step();
        pulse(20);
        watch(40, t_hi, g_hi, b_hi);
        chk("t2_sep_trig", t_hi, 32'd0);
        chk("t2_sep_cand", cand_count, 32'd2);
        chk("t2_sep_acc", acc_count, 32'd2);

        // Prescale 3 over nine candidates
        mode     = 2'd0;
        trig_len = 8'd2;
        gate_len = 8'd3;
        dead_len = 8'd2;
        prescale = 16'd3;
        pat      = '0;
        for (int c = 0; c < 9; c++) begin
            pulse(5);
            watch(12, t_hi, g_hi, b_hi);
            pat[c] = (t_hi != 0);
        end
        chk("t3_pattern", {23'd0, pat}, 32'h124);
        chk("t3_cand", cand_count, 32'd11);
        chk("t3_acc", acc_count, 32'd5);
        prescale = 16'd1;

        // Masked channel and external veto
        chan_mask[3] = 1'b0;
        step();
        pulse(3);
        watch(12, t_hi, g_hi, b_hi);
        chk("t4_mask_busy", b_hi, 32'd0);
        chk("t4_mask_cand", cand_count, 32'd11);
        chan_mask[3] = 1'b1;
        ext_veto = 1'b1;
        pulse(4);
        watch(12, t_hi, g_hi, b_hi);
        ext_veto = 1'b0;
        chk("t4_veto_trig", t_hi, 32'd0);
        chk("t4_veto_cand", cand_count, 32'd11);
        chk("t4_veto_acc", acc_count, 32'd5);

        // Candidate during DEAD is ignored
        dead_len = 8'd10;
        pulse(1);
        repeat (7) step();
        chk("t5_in_dead", {31'd0, busy}, 32'd1);
        pulse(2);
        watch(20, t_hi, g_hi, b_hi);
        chk("t5_dead_trig", t_hi, 32'd0);
        wait_idle();
        chk("t5_cand", cand_count, 32'd12);
        chk("t5_acc", acc_count, 32'd6);

        // Input held high through busy gives exactly one trigger
        inp[7] = 1'b1;
        watch(40, t_hi, g_hi, b_hi);
        inp[7] = 1'b0;
        chk("t6_hold_trig", t_hi, 32'd2);
        wait_idle();
        chk("t6_cand", cand_count, 32'd13);
        chk("t6_acc", acc_count, 32'd7);

        // Reset mid-FIRE aborts asynchronously, then normal operation resumes
        trig_len = 8'd8;
        gate_len = 8'd8;
        dead_len = 8'd2;
        pulse(3);
        step();
        step();
        step();
        chk("t7_pre_trig", {31'd0, trig_out}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("t7_rst_trig", {31'd0, trig_out}, 32'd0);
        chk("t7_rst_gate", {31'd0, gate_out}, 32'd0);
        chk("t7_rst_busy", {31'd0, busy}, 32'd0);
        chk("t7_rst_cand", cand_count, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        pulse(3);
        chk("t7_k_trig", {31'd0, trig_out}, 32'd0);
        step();
        chk("t7_k1_trig", {31'd0, trig_out}, 32'd0);
        step();
        chk("t7_k2_trig", {31'd0, trig_out}, 32'd1);
        chk("t7_k2_busy", {31'd0, busy}, 32'd1);
        chk("t7_cand", cand_count, 32'd1);
        chk("t7_acc", acc_count, 32'd1);
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
